// File: rtl/chiplet_pkg.sv
// Shared chiplet packetstream definitions: field layout, command and length encodings,
// and the arbiter output-register state type.
package chiplet_pkg;

  localparam int PKT_WIDTH = 1076;

  // Field offsets, mode at the LSB.
  localparam int MODE_LSB  = 0;
  localparam int MODE_W    = 1;
  localparam int VALID_LSB = 1;
  localparam int VALID_W   = 1;
  localparam int CMD_LSB   = 2;
  localparam int CMD_W     = 3;
  localparam int LEN_LSB   = 5;
  localparam int LEN_W     = 3;
  localparam int ADDR_LSB  = 8;
  localparam int ADDR_W    = 32;
  localparam int DATA_LSB  = 40;
  localparam int DATA_W    = 1024;
  localparam int TID_LSB   = 1064;
  localparam int TID_W     = 6;
  localparam int DID_LSB   = 1070;
  localparam int DID_W     = 6;

  typedef enum logic [CMD_W-1:0] {
    CMD_RD_REQ = 3'b000,
    CMD_WR_REQ = 3'b001,
    CMD_RD_RSP = 3'b010
  } cmd_e;

  // Payload size carried by a packet, in bytes.
  typedef enum logic [LEN_W-1:0] {
    LEN_4B   = 3'b000,
    LEN_8B   = 3'b001,
    LEN_16B  = 3'b010,
    LEN_32B  = 3'b011,
    LEN_64B  = 3'b100,
    LEN_128B = 3'b101
  } len_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_e;

  // Rewritten transaction ID: requester in the upper two bits, sequence in the lower four.
  function automatic logic [TID_W-1:0] remap_tid(input logic [1:0] req_id,
                                                 input logic [3:0] seq);
    return {req_id, seq};
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first asserted request at or after i_ptr, ascending with wrap.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_pos;

  // NOTE: every variable written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_sum   = '0;
    w_pos   = '0;
    for (int off = 0; off < N; off++) begin
      w_sum = {1'b0, i_ptr} + (IDX_W+1)'(off);
      if (w_sum >= (IDX_W+1)'(N)) begin
        w_sum = w_sum - (IDX_W+1)'(N);
      end
      w_pos = w_sum[IDX_W-1:0];
      if (!o_any && i_req[w_pos]) begin
        o_any          = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
  end

endmodule

// File: rtl/tx_stream_arbiter.sv
// Round-robin arbiter merging NUM_REQ packetstreams into the single master TX FSM input,
// through one output register that can drain and refill in the same cycle.
module tx_stream_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int PKT_WIDTH = 1076,
  parameter bit TID_REMAP = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ*PKT_WIDTH-1:0] i_req_packetstream,
  input  logic [NUM_REQ-1:0]           i_req_packetstream_valid,
  output logic [NUM_REQ-1:0]           o_req_ready,
  output logic [PKT_WIDTH-1:0]         o_master_tx_packetstream,
  output logic                         o_master_tx_packetstream_valid,
  input  logic                         i_master_tx_fsm_ready,
  output logic [$clog2(NUM_REQ)-1:0]   o_grant_id,
  output logic                         o_busy
);

  import chiplet_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  buf_state_e           r_state;
  buf_state_e           w_state_nxt;
  logic [PKT_WIDTH-1:0] r_pkt;
  logic [PKT_WIDTH-1:0] w_sel_pkt;
  logic [PKT_WIDTH-1:0] w_cap_pkt;
  logic [IDX_W-1:0]     r_grant_id;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [IDX_W-1:0]     w_grant_idx;
  logic [NUM_REQ-1:0]   w_grant_oh;
  logic [NUM_REQ-1:0]   w_req_masked;
  logic                 w_grant_any;
  logic                 w_eligible;
  logic [3:0]           r_seq [NUM_REQ];

  // A new packet may be taken whenever the register is empty or is draining this cycle.
  assign w_eligible   = !rst && ((r_state == ST_EMPTY) || i_master_tx_fsm_ready);
  assign w_req_masked = i_req_packetstream_valid & {NUM_REQ{w_eligible}};

  rr_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_picker (
    .i_req   (w_req_masked),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant_oh),
    .o_idx   (w_grant_idx),
    .o_any   (w_grant_any)
  );

  assign o_req_ready = w_grant_oh;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt                    = r_state;
    o_master_tx_packetstream_valid = 1'b0;
    o_busy                         = 1'b0;
    unique case (r_state)
      ST_EMPTY: begin
        if (w_grant_any) begin
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        // Held packet is being discarded during rst, so it must not be offered.
        o_master_tx_packetstream_valid = !rst;
        o_busy                         = 1'b1;
        if (w_grant_any) begin
          w_state_nxt = ST_FULL;
        end else if (i_master_tx_fsm_ready) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    w_sel_pkt = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (w_grant_oh[n]) begin
        w_sel_pkt = i_req_packetstream[n*PKT_WIDTH +: PKT_WIDTH];
      end
    end
    w_cap_pkt = w_sel_pkt;
    if (TID_REMAP) begin
      w_cap_pkt[TID_LSB +: TID_W] = remap_tid(2'(w_grant_idx), r_seq[w_grant_idx]);
    end
  end

  // NOTE: the per-requester sequence counters are flops, not RAM, and are reset explicitly
  // so post-reset TIDs restart at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt      <= '0;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      for (int n = 0; n < NUM_REQ; n++) begin
        r_seq[n] <= '0;
      end
    end else if (w_grant_any) begin
      r_pkt              <= w_cap_pkt;
      r_grant_id         <= w_grant_idx;
      r_rr_ptr           <= (w_grant_idx == IDX_W'(NUM_REQ-1)) ? '0
                                                               : w_grant_idx + IDX_W'(1);
      r_seq[w_grant_idx] <= r_seq[w_grant_idx] + 4'd1;
    end
  end

  assign o_master_tx_packetstream = r_pkt;
  assign o_grant_id               = r_grant_id;

endmodule

// File: tb/tb_tx_stream_arbiter.sv
// Scoreboard bench for tx_stream_arbiter: one TID-remapping instance and one pass-through
// instance share stimulus; expected packets are queued in hand-derived grant order.
module tb_tx_stream_arbiter;
  import chiplet_pkg::*;

  localparam int NR = 4;
  localparam int PW = PKT_WIDTH;

  typedef struct {
    logic [PW-1:0] raw;
    logic [PW-1:0] rem;
    int            id;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR*PW-1:0] req_pkt;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    req_ready_raw;
  logic [PW-1:0]    out_pkt;
  logic [PW-1:0]    out_pkt_raw;
  logic             out_valid;
  logic             out_valid_raw;
  logic             tx_ready = 1'b0;
  logic [1:0]       grant_id;
  logic [1:0]       grant_id_raw;
  logic             busy;
  logic             busy_raw;

  int n_checks   = 0;
  int n_errors   = 0;
  int cycle      = 0;
  int first_xfer = -1;
  int last_out   = -1;
  int out_cnt    = 0;

  logic [PW-1:0] req_q [NR][$];
  exp_t          exp_q [$];
  exp_t          e [20];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  tx_stream_arbiter #(.NUM_REQ(NR), .PKT_WIDTH(PW), .TID_REMAP(1'b1)) dut (
    .clk                            (clk),
    .rst                            (rst),
    .i_req_packetstream             (req_pkt),
    .i_req_packetstream_valid       (req_valid),
    .o_req_ready                    (req_ready),
    .o_master_tx_packetstream       (out_pkt),
    .o_master_tx_packetstream_valid (out_valid),
    .i_master_tx_fsm_ready          (tx_ready),
    .o_grant_id                     (grant_id),
    .o_busy                         (busy)
  );

  tx_stream_arbiter #(.NUM_REQ(NR), .PKT_WIDTH(PW), .TID_REMAP(1'b0)) dut_raw (
    .clk                            (clk),
    .rst                            (rst),
    .i_req_packetstream             (req_pkt),
    .i_req_packetstream_valid       (req_valid),
    .o_req_ready                    (req_ready_raw),
    .o_master_tx_packetstream       (out_pkt_raw),
    .o_master_tx_packetstream_valid (out_valid_raw),
    .i_master_tx_fsm_ready          (tx_ready),
    .o_grant_id                     (grant_id_raw),
    .o_busy                         (busy_raw)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic check_pkt(input string name, input logic [PW-1:0] act,
                           input logic [PW-1:0] want);
    logic [17*64-1:0] a;
    logic [17*64-1:0] b;
    n_checks++;
    if (act !== want) begin
      n_errors++;
      a = '0;
      b = '0;
      a[PW-1:0] = act;
      b[PW-1:0] = want;
      for (int i = 0; i < 17; i++) begin
        if (a[i*64 +: 64] !== b[i*64 +: 64]) begin
          $display("FAIL %s: word %0d got %h expected %h", name, i, a[i*64 +: 64], b[i*64 +: 64]);
          break;
        end
      end
    end
  endtask

  function automatic logic [PW-1:0] mk_pkt(input logic [2:0] cmd);
    logic [17*64-1:0] t;
    for (int i = 0; i < 34; i++) t[i*32 +: 32] = $urandom;
    t[CMD_LSB +: CMD_W] = cmd;
    t[VALID_LSB]        = 1'b1;
    return t[PW-1:0];
  endfunction

  // Queue a packet on requester n; ex carries the packet as it must leave each instance.
  task automatic send(input int n, input int seq, input logic [2:0] cmd, output exp_t ex);
    logic [PW-1:0] p;
    p = mk_pkt(cmd);
    req_q[n].push_back(p);
    ex.raw = p;
    ex.rem = p;
    ex.rem[TID_LSB +: TID_W] = {2'(n), 4'(seq)};
    ex.id  = n;
  endtask

  function automatic bit all_idle();
    bit idle;
    idle = (exp_q.size() == 0) && (req_valid == '0) && !out_valid;
    for (int n = 0; n < NR; n++) if (req_q[n].size() != 0) idle = 1'b0;
    return idle;
  endfunction

  task automatic wait_valid(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check(name, seen, 1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = all_idle();
    end
    check(name, done, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    first_xfer = -1;
    last_out   = -1;
    out_cnt    = 0;
  endtask

  // Requester model: holds each packet until its ready strobe, then presents the next.
  initial begin : driver
    logic [NR-1:0] xfer;
    req_valid = '0;
    req_pkt   = '0;
    forever begin
      @(negedge clk);
      xfer = req_valid & req_ready;
      if (xfer != '0 && first_xfer < 0) first_xfer = cycle;
      @(posedge clk);
      #1;
      for (int n = 0; n < NR; n++) begin
        if (xfer[n] || !req_valid[n]) begin
          if (req_q[n].size() > 0) begin
            req_pkt[n*PW +: PW] = req_q[n].pop_front();
            req_valid[n]        = 1'b1;
          end else begin
            req_valid[n] = 1'b0;
          end
        end
      end
    end
  end

  initial begin : monitor
    exp_t ex;
    forever begin
      @(negedge clk);
      if (out_valid && tx_ready) begin
        out_cnt++;
        last_out = cycle;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: got id %0d expected no packet", grant_id);
        end else begin
          ex = exp_q.pop_front();
          check("grant_id", grant_id, ex.id);
          check_pkt("pkt_remap", out_pkt, ex.rem);
          check("raw_valid", out_valid_raw, 1);
          check_pkt("pkt_raw", out_pkt_raw, ex.raw);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : main
    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_ready", req_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_id", grant_id, 0);
    check_pkt("rst_pkt", out_pkt, '0);

    // Requester 0, three back-to-back writes.
    do_reset();
    tx_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send(0, k, CMD_WR_REQ, e[k]);
      exp_q.push_back(e[k]);
    end
    wait_drain("t1_drain", 50);
    check("t1_count", out_cnt, 3);
    check("t1_latency", last_out - first_xfer, 3);

    // All four requesters valid: strict rotation, no idle cycles.
    do_reset();
    tx_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int n = 0; n < NR; n++) begin
        send(n, r, CMD_WR_REQ, e[r*NR+n]);
        exp_q.push_back(e[r*NR+n]);
      end
    end
    wait_drain("t2_drain", 50);
    check("t2_count", out_cnt, 8);
    check("t2_latency", last_out - first_xfer, 8);

    // Stall with req2 waiting, then drain and refill in one cycle.
    do_reset();
    tx_ready = 1'b0;
    send(0, 0, CMD_WR_REQ, e[0]);
    send(2, 0, CMD_RD_REQ, e[1]);
    exp_q.push_back(e[0]);
    exp_q.push_back(e[1]);
    wait_valid("t3_fill", 20);
    for (int i = 0; i < 5; i++) begin
      check("t3_stall_ready", req_ready, 0);
      check("t3_stall_valid", out_valid, 1);
      check("t3_stall_id", grant_id, 0);
      check_pkt("t3_stall_pkt", out_pkt, e[0].rem);
      @(negedge clk);
    end
    @(posedge clk);
    #1 tx_ready = 1'b1;
    @(negedge clk);
    check("t3_refill_ready", req_ready, 4'b0100);
    wait_drain("t3_drain", 50);
    check("t3_count", out_cnt, 2);

    // Requester 1, seventeen packets: sequence wraps on the last.
    do_reset();
    tx_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      send(1, k % 16, CMD_RD_RSP, e[k]);
      exp_q.push_back(e[k]);
    end
    wait_drain("t4_drain", 80);
    check("t4_count", out_cnt, 17);
    check("t4_latency", last_out - first_xfer, 17);

    // Reset while FULL and stalled: held packet dropped, pointer and sequences restart.
    do_reset();
    tx_ready = 1'b0;
    send(1, 0, CMD_RD_REQ, e[0]);
    send(1, 0, CMD_RD_REQ, e[1]);
    send(3, 0, CMD_RD_RSP, e[2]);
    exp_q.push_back(e[1]);
    exp_q.push_back(e[2]);
    wait_valid("t5_fill", 20);
    check("t5_full_id", grant_id, 1);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    tx_ready = 1'b1;
    @(negedge clk);
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_ready", req_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_post_busy", busy, 0);
    check("t5_post_valid", out_valid, 0);
    check("t5_post_id", grant_id, 0);
    check_pkt("t5_post_pkt", out_pkt, '0);
    check("t5_post_grant", req_ready, 4'b0010);
    wait_drain("t5_drain", 50);
    check("t5_count", out_cnt, 2);

    // Sparse requesters 0 and 2: idle ones skipped without penalty.
    do_reset();
    tx_ready = 1'b1;
    send(0, 0, CMD_WR_REQ, e[0]);
    send(2, 0, CMD_RD_REQ, e[1]);
    send(0, 1, CMD_RD_RSP, e[2]);
    send(2, 1, CMD_WR_REQ, e[3]);
    for (int k = 0; k < 4; k++) exp_q.push_back(e[k]);
    wait_drain("t6_drain", 50);
    check("t6_count", out_cnt, 4);
    check("t6_latency", last_out - first_xfer, 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tx_stream_arbiter.md
TX_STREAM_ARBITER -- requirements
Module: tx_stream_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the master TX FSM (2..8).
REQ-002 SHALL have parameter PKT_WIDTH, default 1076, packetstream width: {did[6], tid[6], data[1024], addr[32], length[3], cmd[3], valid[1], mode[1]}, mode at LSB.
REQ-003 SHALL have parameter TID_REMAP, default 1, which enables TID rewrite with requester ID and sequence number.
REQ-004 clk  input  1  sole clock; all logic on posedge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 i_req_packetstream  input  NUM_REQ*PKT_WIDTH  requester n occupies bits [n*PKT_WIDTH +: PKT_WIDTH].
REQ-007 i_req_packetstream_valid  input  NUM_REQ  per-requester packet valid.
REQ-008 o_req_ready  output  NUM_REQ  per-requester accept strobe.
REQ-009 o_master_tx_packetstream  output  PKT_WIDTH  packet to the master TX FSM.
REQ-010 o_master_tx_packetstream_valid  output  1  output packet valid.
REQ-011 i_master_tx_fsm_ready  input  1  the master TX FSM accepts the packet this cycle.
REQ-012 o_grant_id  output  clog2(NUM_REQ)  source requester of the current output packet.
REQ-013 o_busy  output  1  output register holds a packet.

Function
REQ-014 Handshake: a requester transfer occurs when valid[n] && o_req_ready[n]; an output transfer occurs when o_master_tx_packetstream_valid && i_master_tx_fsm_ready.
REQ-015 A requester SHALL hold its packet stable while valid is high and ready is low; the arbiter SHALL NOT depend on valid dropping without a transfer.
REQ-016 Single output register, states EMPTY and FULL: EMPTY->FULL on a requester transfer; FULL->EMPTY on an output transfer with no new grant; FULL->FULL on simultaneous drain and new grant.
REQ-017 Grant-eligible cycle is EMPTY, or FULL with i_master_tx_fsm_ready=1 (drain and refill in the same cycle, no bubble).
REQ-018 o_req_ready SHALL be one-hot or zero, asserted only in a grant-eligible cycle for the winning valid requester; it is combinational from valids, state and pointer.
REQ-019 Round-robin: search starts at rr_ptr, ascending, wraps from NUM_REQ-1 to 0; after a grant to n, rr_ptr = (n+1) mod NUM_REQ; rr_ptr is unchanged when there is no grant.
REQ-020 Latency: packet visible on the output exactly 1 cycle after its requester transfer; sustained throughput 1 packet/cycle when i_master_tx_fsm_ready stays high.
REQ-021 While FULL and i_master_tx_fsm_ready=0, the output packet, valid and o_grant_id SHALL hold stable.
REQ-022 TID_REMAP=1: on capture, tid field bits[5:4] SHALL be the requester ID (NUM_REQ<=4) and bits[3:0] SHALL be seq[n]; seq[n] increments by 1 on each transfer of requester n, wrapping 15->0. All other fields pass unmodified.
REQ-023 TID_REMAP=0: the packet SHALL pass bit-exact.
REQ-024 Requesters whose valid is low SHALL be skipped with no cycle penalty.
REQ-025 rst asserted mid-packet SHALL discard the held packet; no output transfer occurs in the reset cycle.

Reset
REQ-026 On rst: state EMPTY, o_master_tx_packetstream_valid=0, o_master_tx_packetstream=0, o_grant_id=0, o_busy=0, rr_ptr=0, all seq[n]=0, o_req_ready=0 during rst.

Structure
REQ-027 A shared package chiplet_pkg SHALL hold PKT_WIDTH, the field offsets (MODE, VALID, CMD, LEN, ADDR, DATA, TID, DID), the CMD encodings (RD_REQ=000, WR_REQ=001, RD_RSP=010) and the LENGTH encodings.
REQ-028 The round-robin picker SHALL be one sub-module, rr_picker (inputs req vector and ptr; outputs one-hot grant and index).

Verification
REQ-029 Single requester 0 sends 3 back-to-back write packets with ready=1 -> outputs on cycles 1,2,3 after the first transfer, with tid[3:0]=0,1,2 and tid[5:4]=0.
REQ-030 All 4 valid continuously with ready=1 -> grant order 0,1,2,3,0,1 and no idle cycles.
REQ-031 Output FULL, ready=0 for 5 cycles while req2 is valid -> output is stable, o_req_ready=0; ready=1 -> req2 is granted in the same cycle the old packet drains.
REQ-032 Requester 1 sends 17 packets -> tid[3:0] wraps 15->0 on the 17th, and tid[5:4]=01 throughout.
REQ-033 rst asserted while FULL with ready=0 -> next cycle valid=0, rr_ptr=0, seq reset; the first post-reset grant goes to the lowest valid index.
REQ-034 TID_REMAP=0, random packets -> output equals input bit-exact, in grant order.
